// File: rtl/id_queue.sv
// id_queue: decode-and-buffer stage between fetch and execute.
//
// Raw 32-bit instruction words arrive with their PC over a valid/ready
// handshake. They are decoded on the way in, and the decoded entry goes into a
// DEPTH-entry FIFO. The head entry is presented to the issue stage over a
// second valid/ready handshake.
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-high reset
//   flush         in   synchronous queue clear (redirect)
//   in_valid      in   fetch presents a word
//   in_ready      out  queue can accept (!full)
//   in_inst_code  in   raw instruction word [31:0]
//   in_pc         in   PC of the instruction [DATA_WIDTH-1:0]
//   out_valid     out  head entry valid (!empty)
//   out_ready     in   issue stage consumes the head
//   out_pc        out  head PC
//   out_inst_type out  R / I / J / INVALID
//   out_opcode    out  inst[31:26]
//   out_funct     out  inst[5:0]
//   out_reg_s     out  inst[25:21] (R/I only)
//   out_reg_t     out  inst[20:16] (R/I only)
//   out_reg_d     out  inst[15:11] (all types)
//   out_shift     out  inst[10:6] (R only)
//   out_imm       out  extended immediate (I only)
//   out_jump_addr out  inst[25:0] (J only)
//   count         out  occupancy, 0..DEPTH
module id_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_inst_code,
  input  logic [DATA_WIDTH-1:0] in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [1:0]            out_inst_type,
  output logic [5:0]            out_opcode,
  output logic [5:0]            out_funct,
  output logic [4:0]            out_reg_s,
  output logic [4:0]            out_reg_t,
  output logic [4:0]            out_reg_d,
  output logic [4:0]            out_shift,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic [25:0]           out_jump_addr,
  output logic [CNT_W-1:0]      count
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [1:0] INST_TYPE_R       = 2'd0;
  localparam logic [1:0] INST_TYPE_I       = 2'd1;
  localparam logic [1:0] INST_TYPE_J       = 2'd2;
  localparam logic [1:0] INST_TYPE_INVALID = 2'd3;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [1:0]            inst_type;
    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic [4:0]            reg_s;
    logic [4:0]            reg_t;
    logic [4:0]            reg_d;
    logic [4:0]            shift;
    logic [DATA_WIDTH-1:0] imm;
    logic [25:0]           jump_addr;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  entry_t           entry_d;
  entry_t           head;
  logic [5:0]       dec_opcode;
  logic [1:0]       dec_type;
  logic [DATA_WIDTH-1:0] dec_imm;
  logic             push, pop;

  // Handshake status comes only from registered occupancy.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign count     = count_q;

  // Input-side decode.
  assign dec_opcode = in_inst_code[31:26];

  always_comb begin
    dec_type = INST_TYPE_I;
    if (dec_opcode == 6'h00)
      dec_type = INST_TYPE_R;
    else if (dec_opcode == 6'h02 || dec_opcode == 6'h03)
      dec_type = INST_TYPE_J;
    else if ((dec_opcode >= 6'h14 && dec_opcode <= 6'h1F) || dec_opcode >= 6'h3C)
      dec_type = INST_TYPE_INVALID;
  end

  // ANDI/ORI/XORI zero-extend, LUI shifts into the upper half, everything
  // else in the I class sign-extends.
  always_comb begin
    if (dec_opcode == 6'h0C || dec_opcode == 6'h0D || dec_opcode == 6'h0E)
      dec_imm = DATA_WIDTH'(in_inst_code[15:0]);
    else if (dec_opcode == 6'h0F)
      dec_imm = DATA_WIDTH'({in_inst_code[15:0], 16'h0000});
    else
      dec_imm = DATA_WIDTH'($signed(in_inst_code[15:0]));
  end

  always_comb begin
    entry_d           = '0;
    entry_d.pc        = in_pc;
    entry_d.inst_type = dec_type;
    entry_d.opcode    = dec_opcode;
    entry_d.funct     = in_inst_code[5:0];
    // reg_d is kept for every class: MTC0/MFC0 encode it outside R type.
    entry_d.reg_d     = in_inst_code[15:11];
    case (dec_type)
      INST_TYPE_R: begin
        entry_d.reg_s = in_inst_code[25:21];
        entry_d.reg_t = in_inst_code[20:16];
        entry_d.shift = in_inst_code[10:6];
      end
      INST_TYPE_I: begin
        entry_d.reg_s = in_inst_code[25:21];
        entry_d.reg_t = in_inst_code[20:16];
        entry_d.imm   = dec_imm;
      end
      INST_TYPE_J: begin
        entry_d.jump_addr = in_inst_code[25:0];
      end
      default: begin
      end
    endcase
  end

  // Pointer and occupancy update; flush overrides any push/pop that cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= entry_d;
  end

  // Head read straight from storage; forced to zero when empty so stale
  // slots never leak onto the outputs.
  always_comb begin
    head = '0;
    if (out_valid) head = mem_q[rd_ptr_q];
  end

  assign out_pc        = head.pc;
  assign out_inst_type = head.inst_type;
  assign out_opcode    = head.opcode;
  assign out_funct     = head.funct;
  assign out_reg_s     = head.reg_s;
  assign out_reg_t     = head.reg_t;
  assign out_reg_d     = head.reg_d;
  assign out_shift     = head.shift;
  assign out_imm       = head.imm;
  assign out_jump_addr = head.jump_addr;

endmodule

// File: tb/tb_id_queue.sv
module tb_id_queue;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  localparam logic [1:0] T_R = 2'd0;
  localparam logic [1:0] T_I = 2'd1;
  localparam logic [1:0] T_J = 2'd2;
  localparam logic [1:0] T_X = 2'd3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_inst_code = '0;
  logic [DW-1:0] in_pc = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_pc;
  logic [1:0]    out_inst_type;
  logic [5:0]    out_opcode;
  logic [5:0]    out_funct;
  logic [4:0]    out_reg_s;
  logic [4:0]    out_reg_t;
  logic [4:0]    out_reg_d;
  logic [4:0]    out_shift;
  logic [DW-1:0] out_imm;
  logic [25:0]   out_jump_addr;
  logic [CW-1:0] count;

  int total = 0;
  int bad   = 0;

  id_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_inst_code (in_inst_code),
    .in_pc        (in_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_inst_type(out_inst_type),
    .out_opcode   (out_opcode),
    .out_funct    (out_funct),
    .out_reg_s    (out_reg_s),
    .out_reg_t    (out_reg_t),
    .out_reg_d    (out_reg_d),
    .out_shift    (out_shift),
    .out_imm      (out_imm),
    .out_jump_addr(out_jump_addr),
    .count        (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic        ordy;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        e_valid;
    logic [2:0]  e_count;
    logic [1:0]  e_type;
    logic [5:0]  e_op;
    logic [5:0]  e_fn;
    logic [4:0]  e_rs;
    logic [4:0]  e_rt;
    logic [4:0]  e_rd;
    logic [4:0]  e_sh;
    logic [31:0] e_imm;
    logic [25:0] e_jmp;
    logic [31:0] e_pc;
  } vec_t;

  function automatic vec_t mk(logic iv, logic ordy, logic [31:0] inst, logic [31:0] pc,
                              logic ev, logic [2:0] ec, logic [1:0] et,
                              logic [5:0] eop, logic [5:0] efn,
                              logic [4:0] ers, logic [4:0] ert, logic [4:0] erd, logic [4:0] esh,
                              logic [31:0] eimm, logic [25:0] ejmp, logic [31:0] epc);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.inst = inst; v.pc = pc;
    v.e_valid = ev; v.e_count = ec; v.e_type = et; v.e_op = eop; v.e_fn = efn;
    v.e_rs = ers; v.e_rt = ert; v.e_rd = erd; v.e_sh = esh;
    v.e_imm = eimm; v.e_jmp = ejmp; v.e_pc = epc;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] wrap_word(int k);
    return 32'h2000_0000 | 32'(k);   // addi $0,$0,k
  endfunction

  vec_t vecs[16];

  int   k;
  int   cyc;
  int   mcount;
  logic acc_push, acc_pop;
  int   q_idx[$];

  initial begin
    // Reset state
    #2;
    chk("rst.count", count, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_pc", out_pc, 0);
    chk("rst.out_imm", out_imm, 0);
    #6 rst = 1'b0;
    step();

    //              iv ordy inst          pc         v  c  type op     fn     rs  rt  rd  sh  imm           jmp          pc
    vecs[0]  = mk(1, 0, 32'h012A4020, 32'h100, 1, 1, T_R, 6'h00, 6'h20, 9,  10, 8,  0, 32'h0,        26'h0,       32'h100);
    vecs[1]  = mk(1, 0, 32'h3C01FFFF, 32'h104, 1, 2, T_R, 6'h00, 6'h20, 9,  10, 8,  0, 32'h0,        26'h0,       32'h100);
    vecs[2]  = mk(1, 1, 32'h2021FFFF, 32'h108, 1, 2, T_I, 6'h0F, 6'h3F, 0,  1,  31, 0, 32'hFFFF0000, 26'h0,       32'h104);
    vecs[3]  = mk(1, 1, 32'h3421FFFF, 32'h10C, 1, 2, T_I, 6'h08, 6'h3F, 1,  1,  31, 0, 32'hFFFFFFFF, 26'h0,       32'h108);
    vecs[4]  = mk(0, 1, 32'h0,        32'h0,   1, 1, T_I, 6'h0D, 6'h3F, 1,  1,  31, 0, 32'h0000FFFF, 26'h0,       32'h10C);
    vecs[5]  = mk(0, 1, 32'h0,        32'h0,   0, 0, 2'd0, 6'h00, 6'h00, 0, 0,  0,  0, 32'h0,        26'h0,       32'h0);
    vecs[6]  = mk(1, 0, 32'h0C000040, 32'h200, 1, 1, T_J, 6'h03, 6'h00, 0,  0,  0,  0, 32'h0,        26'h40,      32'h200);
    vecs[7]  = mk(1, 1, 32'h50000000, 32'h204, 1, 1, T_X, 6'h14, 6'h00, 0,  0,  0,  0, 32'h0,        26'h0,       32'h204);
    vecs[8]  = mk(1, 1, 32'hFC21FFFF, 32'h208, 1, 1, T_X, 6'h3F, 6'h3F, 0,  0,  31, 0, 32'h0,        26'h0,       32'h208);
    vecs[9]  = mk(1, 1, 32'h00084080, 32'h20C, 1, 1, T_R, 6'h00, 6'h00, 0,  8,  8,  2, 32'h0,        26'h0,       32'h20C);
    vecs[10] = mk(1, 1, 32'h0BFFFFFF, 32'h210, 1, 1, T_J, 6'h02, 6'h3F, 0,  0,  31, 0, 32'h0,        26'h3FFFFFF, 32'h210);
    vecs[11] = mk(1, 1, 32'h3021FFFF, 32'h214, 1, 1, T_I, 6'h0C, 6'h3F, 1,  1,  31, 0, 32'h0000FFFF, 26'h0,       32'h214);
    vecs[12] = mk(1, 1, 32'h8C41FFFC, 32'h218, 1, 1, T_I, 6'h23, 6'h3C, 2,  1,  31, 0, 32'hFFFFFFFC, 26'h0,       32'h218);
    vecs[13] = mk(1, 1, 32'h4C000000, 32'h21C, 1, 1, T_I, 6'h13, 6'h00, 0,  0,  0,  0, 32'h0,        26'h0,       32'h21C);
    vecs[14] = mk(1, 1, 32'hEC210005, 32'h220, 1, 1, T_I, 6'h3B, 6'h05, 1,  1,  0,  0, 32'h5,        26'h0,       32'h220);
    vecs[15] = mk(0, 1, 32'h0,        32'h0,   0, 0, 2'd0, 6'h00, 6'h00, 0, 0,  0,  0, 32'h0,        26'h0,       32'h0);

    for (int i = 0; i < 16; i++) begin
      in_valid     = vecs[i].iv;
      out_ready    = vecs[i].ordy;
      in_inst_code = vecs[i].inst;
      in_pc        = vecs[i].pc;
      step();
      $display("vec %0d: in=%h pc=%h -> count=%0d head_pc=%h type=%0d imm=%h",
               i, vecs[i].inst, vecs[i].pc, count, out_pc, out_inst_type, out_imm);
      chk($sformatf("v%0d.out_valid", i), out_valid, vecs[i].e_valid);
      chk($sformatf("v%0d.count", i), count, vecs[i].e_count);
      chk($sformatf("v%0d.in_ready", i), in_ready, 1);
      chk($sformatf("v%0d.type", i), out_inst_type, vecs[i].e_type);
      chk($sformatf("v%0d.opcode", i), out_opcode, vecs[i].e_op);
      chk($sformatf("v%0d.funct", i), out_funct, vecs[i].e_fn);
      chk($sformatf("v%0d.reg_s", i), out_reg_s, vecs[i].e_rs);
      chk($sformatf("v%0d.reg_t", i), out_reg_t, vecs[i].e_rt);
      chk($sformatf("v%0d.reg_d", i), out_reg_d, vecs[i].e_rd);
      chk($sformatf("v%0d.shift", i), out_shift, vecs[i].e_sh);
      chk($sformatf("v%0d.imm", i), out_imm, vecs[i].e_imm);
      chk($sformatf("v%0d.jump", i), out_jump_addr, vecs[i].e_jmp);
      chk($sformatf("v%0d.pc", i), out_pc, vecs[i].e_pc);
    end

    // Fill to full with the issue stage stalled.
    out_ready = 1'b0;
    for (k = 0; k < DEPTH; k++) begin
      in_valid = 1'b1; in_inst_code = wrap_word(k); in_pc = 32'h1000 + 32'(4 * k);
      q_idx.push_back(k);
      step();
      $display("fill %0d: count=%0d in_ready=%0d", k, count, in_ready);
    end
    chk("full.count", count, DEPTH);
    chk("full.in_ready", in_ready, 0);
    chk("full.out_valid", out_valid, 1);
    chk("full.head_pc", out_pc, 32'h1000);

    // Push attempt while full plus one pop: only the pop happens.
    in_valid = 1'b1; in_inst_code = wrap_word(k); in_pc = 32'h1000 + 32'(4 * k);
    out_ready = 1'b1;
    void'(q_idx.pop_front());
    step();
    $display("full push+pop: count=%0d in_ready=%0d head_pc=%h", count, in_ready, out_pc);
    chk("fullpop.count", count, DEPTH - 1);
    chk("fullpop.in_ready", in_ready, 1);
    chk("fullpop.head_pc", out_pc, 32'h1004);

    // Stream the rest through with a stuttering consumer, wrapping the pointers.
    mcount = DEPTH - 1;
    cyc = 0;
    while ((k < 3 * DEPTH || mcount > 0) && cyc < 100) begin
      in_valid     = (k < 3 * DEPTH);
      in_inst_code = wrap_word(k);
      in_pc        = 32'h1000 + 32'(4 * k);
      out_ready    = (cyc % 3 != 2);
      acc_push     = in_valid && (mcount < DEPTH);
      acc_pop      = out_ready && (mcount > 0);
      step();
      if (acc_pop) void'(q_idx.pop_front());
      if (acc_push) begin
        q_idx.push_back(k);
        k++;
      end
      mcount = mcount + (acc_push ? 1 : 0) - (acc_pop ? 1 : 0);
      $display("stream %0d: count=%0d head_pc=%h imm=%h", cyc, count, out_pc, out_imm);
      chk($sformatf("s%0d.count", cyc), count, mcount);
      if (mcount > 0) begin
        chk($sformatf("s%0d.head_pc", cyc), out_pc, 32'h1000 + 32'(4 * q_idx[0]));
        chk($sformatf("s%0d.head_imm", cyc), out_imm, q_idx[0]);
      end else begin
        chk($sformatf("s%0d.out_valid", cyc), out_valid, 0);
      end
      cyc++;
    end
    chk("stream.timeout", (cyc >= 100), 0);
    in_valid = 1'b0;
    out_ready = 1'b0;

    // Flush with count=3 while a push and a pop are both offered.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_inst_code = 32'h2000_0100 | 32'(i); in_pc = 32'h2000 + 32'(4 * i);
      step();
    end
    chk("preflush.count", count, 3);
    in_valid = 1'b1; in_inst_code = 32'h2000_0ABC; in_pc = 32'h2FF0;
    out_ready = 1'b1; flush = 1'b1;
    step();
    $display("flush: count=%0d out_valid=%0d in_ready=%0d", count, out_valid, in_ready);
    chk("flush.count", count, 0);
    chk("flush.out_valid", out_valid, 0);
    chk("flush.in_ready", in_ready, 1);
    chk("flush.out_pc", out_pc, 0);
    flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_inst_code = 32'h2000_0DEF; in_pc = 32'h3000;
    step();
    $display("postflush push: count=%0d head_pc=%h", count, out_pc);
    chk("postflush.count", count, 1);
    chk("postflush.head_pc", out_pc, 32'h3000);
    chk("postflush.imm", out_imm, 32'h0DEF);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("postflush.drain", count, 0);
    out_ready = 1'b0;

    // Asynchronous reset between edges with two entries queued.
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_inst_code = 32'h2000_0200 | 32'(i); in_pc = 32'h4000 + 32'(4 * i);
      step();
    end
    in_valid = 1'b0;
    chk("prereset.count", count, 2);
    #2 rst = 1'b1;
    #1;
    $display("async reset: count=%0d out_valid=%0d out_pc=%h", count, out_valid, out_pc);
    chk("arst.count", count, 0);
    chk("arst.out_valid", out_valid, 0);
    chk("arst.in_ready", in_ready, 1);
    chk("arst.out_pc", out_pc, 0);
    #1 rst = 1'b0;
    in_valid = 1'b1; in_inst_code = 32'h012A4020; in_pc = 32'h5000;
    step();
    in_valid = 1'b0;
    $display("post-reset push: count=%0d head_pc=%h type=%0d", count, out_pc, out_inst_type);
    chk("arst.push.count", count, 1);
    chk("arst.push.pc", out_pc, 32'h5000);
    chk("arst.push.type", out_inst_type, T_R);
    chk("arst.push.reg_d", out_reg_d, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_queue.md
Name: id_queue

Overview:
- Decode-and-buffer stage between fetch and execute.
- Accepts raw 32-bit instruction words with their PC over a valid/ready handshake, then decodes instruction type and operand fields at push time.
- Stores decoded entries in a DEPTH-entry FIFO and presents the head entry to the issue stage over a second valid/ready handshake.
- Generalises the combinational decoder with buffering, back-pressure, flush, parametrised data width and immediate extension.

Parameters:
- DATA_WIDTH, 32, width of pc and extended-immediate outputs; must be >=32.
- DEPTH, 4, FIFO entries; power of two, >=2.
- CNT_W, $clog2(DEPTH)+1, width of occupancy count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  synchronous queue clear (branch/exception redirect).
- in_valid  in  1  fetch presents a word.
- in_ready  out  1  queue can accept; equals !full.
- in_inst_code  in  32  raw instruction.
- in_pc  in  DATA_WIDTH  PC of instruction.
- out_valid  out  1  head entry valid; equals !empty.
- out_ready  in  1  issue stage consumes head.
- out_pc  out  DATA_WIDTH  head PC.
- out_inst_type  out  2  `INST_TYPE_R/I/J/INVALID from defs.v.
- out_opcode  out  6  inst[31:26].
- out_funct  out  6  inst[5:0].
- out_reg_s  out  5  inst[25:21].
- out_reg_t  out  5  inst[20:16].
- out_reg_d  out  5  inst[15:11], all types (MTC0/MFC0 need it).
- out_shift  out  5  inst[10:6] for R type, else 0.
- out_imm  out  DATA_WIDTH  extended immediate, I type only, else 0.
- out_jump_addr  out  26  inst[25:0] for J type, else 0.
- count  out  CNT_W  occupancy 0..DEPTH.

Behaviour:
- Classification, on in_inst_code:
  - opcode 0x00 -> R.
  - 0x02 or 0x03 -> J.
  - 0x14..0x1F or 0x3C..0x3F -> INVALID.
  - all others -> I.
- INVALID entries are still queued. reg_s, reg_t, shift, imm and jump_addr are forced to 0; reg_d keeps inst[15:11].
- Immediate extension, for I type:
  - opcode 0x0C/0x0D/0x0E: zero-extend inst[15:0].
  - 0x0F (LUI): {inst[15:0],16'b0}, zero-extended to DATA_WIDTH.
  - otherwise: sign-extend inst[15:0].
- Decode is combinational on the input side. The decoded entry is written into storage on push. No decode logic on the output side.
- Handshakes:
  - push = in_valid & in_ready & !flush.
  - pop = out_valid & out_ready & !flush.
  - in_ready and out_valid depend only on registered state, with no combinational path from in_valid or out_ready.
- Latency:
  - A word pushed at edge N is visible on out_* with out_valid=1 after edge N.
  - There is no same-cycle bypass into an empty queue.
- Outputs read the head slot combinationally from registers. When empty, all out_* data fields are 0.
- Pointers: wr_ptr/rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH. count tracks occupancy.
- Simultaneous push and pop:
  - Allowed when 0<count<DEPTH; count is unchanged and both pointers advance.
  - When full, in_ready=0 so no push, even if a pop occurs that cycle.
  - When empty, out_valid=0 so no pop.
- Flush:
  - Next edge sets wr_ptr=rd_ptr=0 and count=0.
  - Any push or pop that cycle is discarded.
  - in_ready=1 the following cycle.
- Reset (async, rst=1):
  - Pointers and count go to 0; out_valid=0; in_ready=1; all out_* data = 0.
  - Storage contents need not be cleared.
  - Reset mid-operation drops all entries immediately; the first edge after deassertion behaves as an empty queue.

Test Plan:
- Reset, then push 0x012A4020 (add $8,$9,$10) at pc 0x100 -> next cycle: out_valid=1, R, reg_s=9, reg_t=10, reg_d=8, funct=0x20, imm=0, count=1.
- Push 0x3C01FFFF (lui), 0x2021FFFF (addi), 0x3421FFFF (ori), then pop all -> imm 0xFFFF0000, 0xFFFFFFFF, 0x0000FFFF in order.
- Push 0x0C000040 (jal) -> J, jump_addr=0x0000040, reg_s=reg_t=0. Push 0x50000000 -> INVALID, other fields 0.
- Hold out_ready=0 and push DEPTH words -> count=DEPTH, in_ready=0. Assert in_valid plus one pop -> count=DEPTH-1. Next cycle in_ready=1. Continue to 3×DEPTH words -> FIFO order preserved across wrap.
- With count=3, assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, flushed word absent.
- Assert rst asynchronously between edges with count=2 -> out_valid=0 and count=0 immediately. After release, a push completes normally.
